credit_tracker: RTL and testbench

CREDIT_TRACKER -- requirements
Module: credit_tracker

---
 rtl/vend_pkg.sv | 28 ++
 rtl/change_selector.sv | 31 +++
 rtl/credit_tracker.sv | 161 ++++++++++++++++
 tb/tb_credit_tracker.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the credit tracker:
// FSM state enum, coin denominations, default register width.
package vend_pkg;

    localparam int CREDIT_W_DEF = 8;

    localparam int DENOM_1  = 1;
    localparam int DENOM_5  = 5;
    localparam int DENOM_10 = 10;
    localparam int DENOM_20 = 20;

    typedef enum logic [2:0] {
        COLLECT,
        VEND,
        CHANGE,
        GAP,
        DONE
    } state_t;

    // Pulse vector order is {20, 10, 5, 1}
    function automatic int unsigned denom_sum(input logic [3:0] p);
        return (p[0] ? DENOM_1  : 0) +
               (p[1] ? DENOM_5  : 0) +
               (p[2] ? DENOM_10 : 0) +
               (p[3] ? DENOM_20 : 0);
    endfunction

endpackage

// File: rtl/change_selector.sv
// Greedy change picker: largest denomination not above the credit.
// One-hot output order is {20, 10, 5, 1}; all zero when credit is 0.
module change_selector
    import vend_pkg::*;
#(
    parameter int W = CREDIT_W_DEF
) (
    input  logic [W-1:0] i_credit,
    output logic [3:0]   o_denom,
    output logic [W-1:0] o_value
);

    always_comb begin
        o_denom = '0;
        o_value = '0;
        if (i_credit >= W'(DENOM_20)) begin
            o_denom = 4'b1000;
            o_value = W'(DENOM_20);
        end else if (i_credit >= W'(DENOM_10)) begin
            o_denom = 4'b0100;
            o_value = W'(DENOM_10);
        end else if (i_credit >= W'(DENOM_5)) begin
            o_denom = 4'b0010;
            o_value = W'(DENOM_5);
        end else if (i_credit != '0) begin
            o_denom = 4'b0001;
            o_value = W'(DENOM_1);
        end
    end

endmodule

// File: rtl/credit_tracker.sv
// Vending credit tracker: coin collection, price setup, vend and change.
// CREDIT_TRACKER_CHANGE_RETURN_EN enables greedy change return.
module credit_tracker
    import vend_pkg::*;
#(
    parameter int                  CREDIT_W   = CREDIT_W_DEF,
    parameter logic [CREDIT_W-1:0] PRICE_INIT = CREDIT_W'(25),
    parameter logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(200)
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                on_m_1,
    input  logic                on_m_5,
    input  logic                on_m_10,
    input  logic                on_m_20,
    input  logic                on_inc_1,
    input  logic                on_inc_5,
    input  logic                on_inc_10,
    input  logic                on_inc_20,
    input  logic                o_cancel,
    input  logic                buy_btn,
    output logic                enough_payment,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] price,
    output logic                vend,
    output logic                chg_1,
    output logic                chg_5,
    output logic                chg_10,
    output logic                chg_20,
    output logic                busy,
    output logic                m_rst
);

    localparam int SW = CREDIT_W + 6;

`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
    localparam state_t REFUND_ST = CHANGE;
`else
    localparam state_t REFUND_ST = DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic                r_enough;
    logic [SW-1:0]       w_credit_sum;
    logic [SW-1:0]       w_price_sum;
    logic [CREDIT_W-1:0] w_credit_add;
    logic [CREDIT_W-1:0] w_price_add;
    logic                w_buy;

    assign w_credit_sum = SW'(r_credit) +
        SW'(denom_sum({on_m_20, on_m_10, on_m_5, on_m_1}));
    assign w_price_sum = SW'(r_price) +
        SW'(denom_sum({on_inc_20, on_inc_10, on_inc_5, on_inc_1}));

    assign w_credit_add = (w_credit_sum > SW'(MAX_CREDIT)) ?
        MAX_CREDIT : w_credit_sum[CREDIT_W-1:0];
    assign w_price_add = (w_price_sum > SW'({CREDIT_W{1'b1}})) ?
        '1 : w_price_sum[CREDIT_W-1:0];

    assign w_buy = buy_btn && r_enough;

`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
    logic [3:0]          w_chg_denom;
    logic [CREDIT_W-1:0] w_chg_value;

    change_selector #(
        .W (CREDIT_W)
    ) u_sel (
        .i_credit (r_credit),
        .o_denom  (w_chg_denom),
        .o_value  (w_chg_value)
    );
`endif

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            COLLECT: begin
                if (o_cancel) begin
                    w_next = REFUND_ST;
                end else if (w_buy) begin
                    w_next = VEND;
                end
            end
            VEND:    w_next = REFUND_ST;
            CHANGE:  w_next = (r_credit != '0) ? GAP : DONE;
            GAP:     w_next = CHANGE;
            DONE:    w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    // Enough flag lags the credit/price registers by one cycle
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_credit <= '0;
            r_price  <= PRICE_INIT;
            r_enough <= 1'b0;
        end else begin
            r_enough <= (r_state != DONE) &&
                        (r_credit >= r_price) && (r_price != '0);
            unique case (r_state)
                COLLECT: begin
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
                    r_credit <= w_credit_add;
`else
                    r_credit <= o_cancel ? '0 : w_credit_add;
`endif
                    if (r_credit == '0) begin
                        r_price <= w_price_add;
                    end
                end
                VEND: begin
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
                    r_credit <= r_credit - r_price;
`else
                    r_credit <= '0;
`endif
                end
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
                CHANGE: r_credit <= r_credit - w_chg_value;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        vend   = 1'b0;
        chg_1  = 1'b0;
        chg_5  = 1'b0;
        chg_10 = 1'b0;
        chg_20 = 1'b0;
        m_rst  = 1'b0;
        busy   = (r_state != COLLECT);
        unique case (r_state)
            VEND: vend = 1'b1;
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
            CHANGE: {chg_20, chg_10, chg_5, chg_1} = w_chg_denom;
`endif
            DONE:    m_rst = 1'b1;
            default: ;
        endcase
    end

    assign enough_payment = r_enough;
    assign credit         = r_credit;
    assign price          = r_price;

endmodule

// File: tb/tb_credit_tracker.sv
// Self-checking bench for credit_tracker: directed scenarios plus
// random traffic compared against a transaction-level schedule model.
module tb_credit_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] m;
    logic [3:0] inc;
    logic       cancel;
    logic       buy;

    logic       enough_payment;
    logic [7:0] credit;
    logic [7:0] price;
    logic       vend;
    logic       chg_1, chg_5, chg_10, chg_20;
    logic       busy;
    logic       m_rst;
    logic [3:0] chg;

    assign chg = {chg_20, chg_10, chg_5, chg_1};

    always #5 clk = ~clk;

    credit_tracker dut (
        .clk            (clk),
        .i_rst_n        (rst_n),
        .on_m_1         (m[0]),
        .on_m_5         (m[1]),
        .on_m_10        (m[2]),
        .on_m_20        (m[3]),
        .on_inc_1       (inc[0]),
        .on_inc_5       (inc[1]),
        .on_inc_10      (inc[2]),
        .on_inc_20      (inc[3]),
        .o_cancel       (cancel),
        .buy_btn        (buy),
        .enough_payment (enough_payment),
        .credit         (credit),
        .price          (price),
        .vend           (vend),
        .chg_1          (chg_1),
        .chg_5          (chg_5),
        .chg_10         (chg_10),
        .chg_20         (chg_20),
        .busy           (busy),
        .m_rst          (m_rst)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // One entry per busy cycle: what the outputs must show then
    typedef struct packed {
        logic       vend;
        logic [3:0] chg;
        logic       mrst;
        logic [7:0] cr;
    } ev_t;

    ev_t q[$];
    int  m_credit = 0;
    int  m_price  = 25;
    bit  m_enough = 0;

    function automatic int coin_val(input logic [3:0] v);
        return (v[0] ? 1 : 0) + (v[1] ? 5 : 0) +
               (v[2] ? 10 : 0) + (v[3] ? 20 : 0);
    endfunction

    function automatic void push_ev(input logic v, input logic [3:0] c,
                                    input logic r, input int cr);
        ev_t e;
        e.vend = v;
        e.chg  = c;
        e.mrst = r;
        e.cr   = 8'(cr);
        q.push_back(e);
    endfunction

    function automatic void push_refund(input int amt);
        int r;
        int d;
        logic [3:0] oh;
        r = amt;
        while (r > 0) begin
            if (r >= 20) begin d = 20; oh = 4'b1000; end
            else if (r >= 10) begin d = 10; oh = 4'b0100; end
            else if (r >= 5) begin d = 5; oh = 4'b0010; end
            else begin d = 1; oh = 4'b0001; end
            push_ev(1'b0, oh, 1'b0, r);
            r = r - d;
            push_ev(1'b0, 4'b0000, 1'b0, r);
        end
        push_ev(1'b0, 4'b0000, 1'b0, 0);
        push_ev(1'b0, 4'b0000, 1'b1, 0);
    endfunction

    function automatic int shown_credit();
        return (q.size() > 0) ? int'(q[0].cr) : m_credit;
    endfunction

    int  md_cc, md_cp, md_c2;
    bit  md_new_en, md_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_credit = 0;
            m_price  = 25;
            m_enough = 0;
        end else begin
            md_cc     = shown_credit();
            md_cp     = m_price;
            md_done   = (q.size() > 0) && q[0].mrst;
            md_new_en = !md_done && (md_cc >= md_cp) && (md_cp != 0);
            if (q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) m_credit = 0;
            end else begin
                md_c2 = m_credit + coin_val(m);
                if (md_c2 > 200) md_c2 = 200;
                if (m_credit == 0) begin
                    m_price = m_price + coin_val(inc);
                    if (m_price > 255) m_price = 255;
                end
                if (cancel) begin
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
                    push_refund(md_c2);
`else
                    push_ev(1'b0, 4'b0000, 1'b1, 0);
`endif
                    m_credit = 0;
                end else if (buy && m_enough) begin
                    push_ev(1'b1, 4'b0000, 1'b0, md_c2);
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
                    push_refund(md_c2 - md_cp);
`else
                    push_ev(1'b0, 4'b0000, 1'b1, 0);
`endif
                    m_credit = 0;
                end else begin
                    m_credit = md_c2;
                end
            end
            m_enough = md_new_en;
        end
    end

    logic [23:0] exp_v, act_v;
    ev_t         cur;

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0) cur = q[0];
            else cur = '{vend: 1'b0, chg: 4'b0, mrst: 1'b0,
                         cr: 8'(m_credit)};
            exp_v = {cur.cr, 8'(m_price), m_enough, cur.vend, cur.chg,
                     (q.size() > 0), cur.mrst};
            act_v = {credit, price, enough_payment, vend, chg, busy, m_rst};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle t=%0t got cr=%0d pr=%0d en=%b v=%b chg=%b busy=%b mrst=%b want cr=%0d pr=%0d en=%b v=%b chg=%b busy=%b mrst=%b",
                         $time, act_v[23:16], act_v[15:8], act_v[7],
                         act_v[6], act_v[5:2], act_v[1], act_v[0],
                         exp_v[23:16], exp_v[15:8], exp_v[7],
                         exp_v[6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
            checks++;
            if ($countones(chg) > 1) begin
                errors++;
                $display("FAIL onehot t=%0t got chg=%b want at most one", $time, chg);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drv(input logic [3:0] mm, input logic [3:0] ii,
                       input logic c, input logic b);
        m      = mm;
        inc    = ii;
        cancel = c;
        buy    = b;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            drv(4'b0, 4'b0, 1'b0, 1'b0);
            k++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: got busy=1 want 0 within %0d cycles", limit);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        m      = '0;
        inc    = '0;
        cancel = 1'b0;
        buy    = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_credit", credit, 0);
        chk("rst_price", price, 25);
        chk("rst_busy", busy, 0);
        chk("rst_enough", enough_payment, 0);
        rst_n = 1'b1;

        // Price setup only while credit is zero
        drv(4'b0000, 4'b0010, 1'b0, 1'b0);
        chk("inc_at_zero", price, 30);
        drv(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk("coin5", credit, 5);
        drv(4'b0000, 4'b0010, 1'b0, 1'b0);
        chk("inc_ignored", price, 30);
        drv(4'b0000, 4'b0000, 1'b1, 1'b0);
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
        chk("cancel5_chg", chg, 4'b0010);
`else
        chk("cancel5_mrst", m_rst, 1);
        chk("cancel5_credit", credit, 0);
`endif
        wait_idle(30);
        rst_n = 1'b0;
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst_price2", price, 25);

        // Exact payment
        drv(4'b1000, 4'b0000, 1'b0, 1'b0);
        chk("pay20", credit, 20);
        drv(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk("pay25", credit, 25);
        chk("enough_lag", enough_payment, 0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("enough_set", enough_payment, 1);
        drv(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("vend_pulse", vend, 1);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("after_vend_credit", credit, 0);
        chk("after_vend_vend", vend, 0);
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
`endif
        chk("exact_mrst", m_rst, 1);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("exact_idle", busy, 0);

        // Overpayment by 15
        drv(4'b1000, 4'b0000, 1'b0, 1'b0);
        drv(4'b1000, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("over_vend_credit", credit, 40);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
        chk("over_chg10", chg, 4'b0100);
        chk("over_credit15", credit, 15);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("over_gap", chg, 0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("over_chg5", chg, 4'b0010);
`else
        chk("over_mrst", m_rst, 1);
        chk("over_credit0", credit, 0);
        chk("over_nochg", chg, 0);
`endif
        wait_idle(30);

        // Cancel with 16 (simultaneous coins)
        drv(4'b0111, 4'b0000, 1'b0, 1'b0);
        chk("sum16", credit, 16);
        drv(4'b0000, 4'b0000, 1'b1, 1'b0);
`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
        chk("c16_chg10", chg, 4'b0100);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("c16_gap1", chg, 0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("c16_chg5", chg, 4'b0010);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("c16_gap2", chg, 0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("c16_chg1", chg, 4'b0001);
`else
        chk("c16_mrst", m_rst, 1);
        chk("c16_novend", vend, 0);
`endif
        wait_idle(30);

        // Saturation
        repeat (11) drv(4'b1000, 4'b0000, 1'b0, 1'b0);
        chk("saturate", credit, 200);
        drv(4'b0000, 4'b0000, 1'b1, 1'b0);
        wait_idle(40);

`ifdef CREDIT_TRACKER_CHANGE_RETURN_EN
        // Reset during a gap
        drv(4'b1100, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("gap_chg20", chg, 4'b1000);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("gap_credit10", credit, 10);
        rst_n = 1'b0;
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("gaprst_credit", credit, 0);
        chk("gaprst_busy", busy, 0);
        repeat (3) begin
            drv(4'b0000, 4'b0000, 1'b0, 1'b0);
            chk("gaprst_nomrst", m_rst, 0);
        end
`endif

        // Reset during vend
        drv(4'b1100, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("rv_vend", vend, 1);
        rst_n = 1'b0;
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rv_credit", credit, 0);
        chk("rv_vend0", vend, 0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("rv_nomrst", m_rst, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            m      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            inc    = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0;
            cancel = ($urandom_range(0, 19) == 0);
            buy    = ($urandom_range(0, 5) == 0);
            rst_n  = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (3) drv(4'b0000, 4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
